riscv_mmio_bridge: RTL and testbench

RISCV_MMIO_BRIDGE -- requirements
Module: riscv_mmio_bridge

---
 rtl/riscv_mmio_bridge.sv | 189 ++++++++++++++++++
 tb/tb_riscv_mmio_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mmio_bridge.sv
// riscv_mmio_bridge: splits data-side stores between the data cache and a
// 256-byte memory-mapped IO window holding switches, LEDs, a timer and an
// interrupt controller. Loads and stores complete in the cycle presented.

`ifndef CACHE_D_WRITE_LEN
`define CACHE_D_WRITE_LEN 2
`endif
`ifndef CACHE_D_WRITE_SB
`define CACHE_D_WRITE_SB 2'd0
`endif
`ifndef CACHE_D_WRITE_SH
`define CACHE_D_WRITE_SH 2'd1
`endif
`ifndef CACHE_D_WRITE_SW
`define CACHE_D_WRITE_SW 2'd2
`endif

module riscv_mmio_bridge #(
    parameter logic [31:0] IO_BASE    = 32'hFFFFFC00,
    parameter int unsigned SW_WIDTH   = 24,
    parameter int unsigned LED_WIDTH  = 32,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cache_d_write_en,
    input  logic [`CACHE_D_WRITE_LEN-1:0] cache_d_write,
    input  logic [31:0]                   addr,
    input  logic [31:0]                   data_to_cache,
    input  logic [31:0]                   mem_rdata,
    input  logic [SW_WIDTH-1:0]           sw,
    output logic [31:0]                   data_out,
    output logic                          mem_write_en,
    output logic [LED_WIDTH-1:0]          led,
    output logic                          irq
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [5:0] {
        REG_SW     = 6'h00,
        REG_LED    = 6'h01,
        REG_COUNT  = 6'h02,
        REG_CMP    = 6'h03,
        REG_STATUS = 6'h04,
        REG_CTRL   = 6'h05
    } reg_off_e;

    logic                 is_io;
    logic                 io_wr;
    logic [5:0]           off;
    logic [31:0]          io_rdata;
    logic [31:0]          merged;

    logic [31:0]          count_r;
    logic [31:0]          cmp_r;
    logic [3:0]           ctrl_r;
    logic                 tmatch;
    logic                 swchg;

    logic [SW_WIDTH-1:0]  s1;
    logic [SW_WIDTH-1:0]  s2;
    logic [SW_WIDTH-1:0]  sync_last;
    logic [SW_WIDTH-1:0]  stable;
    logic [CNT_W-1:0]     cnt;

    logic                 deb_fire;
    logic                 tmatch_set;
    logic                 wr_led;
    logic                 wr_count;
    logic                 wr_cmp;
    logic                 wr_status;
    logic                 wr_ctrl;

    // Overlay byte/halfword store data onto the current register value.
    function automatic logic [31:0] lane_merge(
        input logic [31:0]                   cur,
        input logic [31:0]                   wd,
        input logic [`CACHE_D_WRITE_LEN-1:0] size,
        input logic [1:0]                    a
    );
        logic [31:0] r;
        r = cur;
        case (size)
            `CACHE_D_WRITE_SB: begin
                case (a)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            `CACHE_D_WRITE_SH: begin
                if (a[1]) r[31:16] = wd[15:0];
                else      r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    assign is_io        = (addr & 32'hFFFFFF00) == IO_BASE;
    assign io_wr        = cache_d_write_en & is_io;
    assign off          = addr[7:2];
    assign mem_write_en = cache_d_write_en & ~is_io;
    assign data_out     = is_io ? io_rdata : mem_rdata;
    assign merged       = lane_merge(io_rdata, data_to_cache, cache_d_write, addr[1:0]);

    assign tmatch_set = ctrl_r[0] && (count_r == cmp_r);
    assign deb_fire   = (s2 != stable) && (s2 == sync_last) && (cnt == CNT_MAX);

    // Register read mux for the IO window; unused bits and offsets read zero.
    always_comb begin
        io_rdata = '0;
        case (off)
            REG_SW:     io_rdata[SW_WIDTH-1:0]  = stable;
            REG_LED:    io_rdata[LED_WIDTH-1:0] = led;
            REG_COUNT:  io_rdata                = count_r;
            REG_CMP:    io_rdata                = cmp_r;
            REG_STATUS: io_rdata[1:0]           = {swchg, tmatch};
            REG_CTRL:   io_rdata[3:0]           = ctrl_r;
            default:    io_rdata                = '0;
        endcase
    end

    // Per-register write strobes.
    always_comb begin
        wr_led    = io_wr && (off == REG_LED);
        wr_count  = io_wr && (off == REG_COUNT);
        wr_cmp    = io_wr && (off == REG_CMP);
        wr_status = io_wr && (off == REG_STATUS);
        wr_ctrl   = io_wr && (off == REG_CTRL);
    end

    // Switch synchronizer and debounce: a new level must persist for
    // DEB_CYCLES consecutive edges past the synchronizer before it is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            sync_last <= '0;
            stable    <= '0;
            cnt       <= '0;
        end else begin
            s1        <= sw;
            s2        <= s1;
            sync_last <= s2;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (s2 != sync_last) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Software-visible registers, timer, status flags and registered irq.
    // Software writes to COUNT override the timer; flag sets override W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led     <= '0;
            count_r <= '0;
            cmp_r   <= '1;
            ctrl_r  <= '0;
            tmatch  <= 1'b0;
            swchg   <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (wr_led)  led    <= merged[LED_WIDTH-1:0];
            if (wr_cmp)  cmp_r  <= merged;
            if (wr_ctrl) ctrl_r <= merged[3:0];

            if (wr_count)
                count_r <= merged;
            else if (ctrl_r[0])
                count_r <= (tmatch_set && ctrl_r[3]) ? '0 : count_r + 32'd1;

            tmatch <= tmatch_set | (tmatch & ~(wr_status & merged[0]));
            swchg  <= deb_fire   | (swchg  & ~(wr_status & merged[1]));
            irq    <= (tmatch & ctrl_r[2]) | (swchg & ctrl_r[1]);
        end
    end

endmodule

// File: tb/tb_riscv_mmio_bridge.sv
// Bench for riscv_mmio_bridge: fixed vectors, directed multi-cycle sequences
// and randomized traffic compared against a behavioural model.

`ifndef CACHE_D_WRITE_LEN
`define CACHE_D_WRITE_LEN 2
`endif
`ifndef CACHE_D_WRITE_SB
`define CACHE_D_WRITE_SB 2'd0
`endif
`ifndef CACHE_D_WRITE_SH
`define CACHE_D_WRITE_SH 2'd1
`endif
`ifndef CACHE_D_WRITE_SW
`define CACHE_D_WRITE_SW 2'd2
`endif

module tb_riscv_mmio_bridge;

    localparam logic [31:0] B   = 32'hFFFFFC00;
    localparam int          SWW = 24;
    localparam int          LDW = 32;
    localparam int          DEB = 4;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          en;
    logic [`CACHE_D_WRITE_LEN-1:0] size;
    logic [31:0]                   addr;
    logic [31:0]                   wdata;
    logic [31:0]                   mem_rdata;
    logic [SWW-1:0]                sw;
    logic [31:0]                   data_out;
    logic                          mem_write_en;
    logic [LDW-1:0]                led;
    logic                          irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_mmio_bridge #(
        .IO_BASE(B),
        .SW_WIDTH(SWW),
        .LED_WIDTH(LDW),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cache_d_write_en(en),
        .cache_d_write(size),
        .addr(addr),
        .data_to_cache(wdata),
        .mem_rdata(mem_rdata),
        .sw(sw),
        .data_out(data_out),
        .mem_write_en(mem_write_en),
        .led(led),
        .irq(irq)
    );

    // ---------------- behavioural model ----------------
    logic [31:0]    m_led, m_count, m_cmp;
    logic [3:0]     m_ctrl;
    logic           m_tmatch, m_swchg, m_irq;
    logic [SWW-1:0] m_stable;
    logic [SWW-1:0] m_hist [DEB+3];   // sampled sw, newest at index 0

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_is_io(input logic [31:0] a);
        return (a & 32'hFFFFFF00) == B;
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] o);
        logic [31:0] r;
        r = '0;
        case (o)
            6'd0: r[SWW-1:0] = m_stable;
            6'd1: r = m_led;
            6'd2: r = m_count;
            6'd3: r = m_cmp;
            6'd4: r = {30'b0, m_swchg, m_tmatch};
            6'd5: r = {28'b0, m_ctrl};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] cur, input logic [31:0] d,
                                            input logic [`CACHE_D_WRITE_LEN-1:0] sz,
                                            input logic [1:0] a);
        logic [31:0] mask;
        int          sh;
        if (sz == `CACHE_D_WRITE_SB) begin
            sh   = 8 * int'(a);
            mask = 32'hFF << sh;
            return (cur & ~mask) | ((d & 32'hFF) << sh);
        end else if (sz == `CACHE_D_WRITE_SH) begin
            sh   = a[1] ? 16 : 0;
            mask = 32'hFFFF << sh;
            return (cur & ~mask) | ((d & 32'hFFFF) << sh);
        end
        return d;
    endfunction

    task automatic m_reset();
        m_led = '0; m_count = '0; m_cmp = 32'hFFFFFFFF; m_ctrl = '0;
        m_tmatch = 0; m_swchg = 0; m_irq = 0; m_stable = '0;
        for (int i = 0; i < DEB + 3; i++) m_hist[i] = '0;
    endtask

    // One clock edge: a switch level is accepted once the DEB+1 samples
    // that sit two or more edges back all agree and differ from the current value.
    task automatic m_edge();
        bit          wr, fire, same, match, irq_n;
        logic [5:0]  o;
        logic [31:0] mg, cnt_n;
        wr = en && m_is_io(addr);
        o  = addr[7:2];
        mg = m_merge(m_read(o), wdata, size, addr[1:0]);

        for (int i = DEB + 2; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = sw;
        same = 1;
        for (int i = 3; i <= DEB + 2; i++) if (m_hist[i] != m_hist[2]) same = 0;
        fire = same && (m_hist[2] != m_stable);

        irq_n = (m_tmatch && m_ctrl[2]) || (m_swchg && m_ctrl[1]);
        match = m_ctrl[0] && (m_count == m_cmp);
        if (wr && o == 6'd2)  cnt_n = mg;
        else if (m_ctrl[0])   cnt_n = (match && m_ctrl[3]) ? 32'd0 : m_count + 1;
        else                  cnt_n = m_count;

        if (wr && o == 6'd1) m_led  = mg;
        if (wr && o == 6'd3) m_cmp  = mg;
        if (wr && o == 6'd5) m_ctrl = mg[3:0];
        m_tmatch = match || (m_tmatch && !(wr && o == 6'd4 && mg[0]));
        m_swchg  = fire  || (m_swchg  && !(wr && o == 6'd4 && mg[1]));
        if (fire) m_stable = m_hist[2];
        m_count = cnt_n;
        m_irq   = irq_n;
    endtask

    // Check all outputs against the model, then advance one clock.
    task automatic cyc();
        logic [31:0] exp_do;
        #1;
        if (rst) m_reset();
        exp_do = m_is_io(addr) ? m_read(addr[7:2]) : mem_rdata;
        check("m_data_out", data_out, exp_do);
        check("m_mem_write_en", {31'b0, mem_write_en}, {31'b0, en && !m_is_io(addr)});
        check("m_led", led, m_led);
        check("m_irq", {31'b0, irq}, {31'b0, m_irq});
        if (!rst) m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        en = 1; size = `CACHE_D_WRITE_SW; addr = a; wdata = d;
        cyc();
        en = 0;
    endtask

    // ---------------- fixed vectors ----------------
    typedef struct {
        string                          name;
        logic                           en;
        logic [`CACHE_D_WRITE_LEN-1:0]  size;
        logic [31:0]                    addr;
        logic [31:0]                    wdata;
        logic [31:0]                    mrd;
        logic [31:0]                    exp_do;
        logic                           exp_we;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{"st_led_sw",    1, `CACHE_D_WRITE_SW, B+32'h04, 32'h12345678, 32'h11111111, 32'h00000000, 0};
        vecs[1]  = '{"st_led_sb",    1, `CACHE_D_WRITE_SB, B+32'h06, 32'h000000AB, 32'h11111111, 32'h12345678, 0};
        vecs[2]  = '{"ld_led",       0, `CACHE_D_WRITE_SW, B+32'h04, 32'h0,        32'h11111111, 32'h12AB5678, 0};
        vecs[3]  = '{"st_mem",       1, `CACHE_D_WRITE_SW, 32'h100,  32'h55,       32'hDEADBEEF, 32'hDEADBEEF, 1};
        vecs[4]  = '{"ld_unmapped",  0, `CACHE_D_WRITE_SW, B+32'h40, 32'h0,        32'h22222222, 32'h00000000, 0};
        vecs[5]  = '{"st_led_sh_hi", 1, `CACHE_D_WRITE_SH, B+32'h06, 32'h1234CAFE, 32'h0,        32'h12AB5678, 0};
        vecs[6]  = '{"st_led_sh_lo", 1, `CACHE_D_WRITE_SH, B+32'h04, 32'hFFFF1234, 32'h0,        32'hCAFE5678, 0};
        vecs[7]  = '{"st_unmapped",  1, `CACHE_D_WRITE_SW, B+32'h3C, 32'hFFFFFFFF, 32'h0,        32'h00000000, 0};
        vecs[8]  = '{"ld_led2",      0, `CACHE_D_WRITE_SW, B+32'h07, 32'h0,        32'h0,        32'hCAFE1234, 0};
        vecs[9]  = '{"st_outside",   1, `CACHE_D_WRITE_SW, B+32'h104,32'h0,        32'h33333333, 32'h33333333, 1};
        vecs[10] = '{"st_ctrl_b1",   1, `CACHE_D_WRITE_SB, B+32'h15, 32'h000000FF, 32'h0,        32'h00000000, 0};
        vecs[11] = '{"ld_ctrl",      0, `CACHE_D_WRITE_SW, B+32'h14, 32'h0,        32'h0,        32'h00000000, 0};
        vecs[12] = '{"st_cmp_b3",    1, `CACHE_D_WRITE_SB, B+32'h0F, 32'h00000012, 32'h0,        32'hFFFFFFFF, 0};
        vecs[13] = '{"ld_cmp",       0, `CACHE_D_WRITE_SW, B+32'h0C, 32'h0,        32'h0,        32'h12FFFFFF, 0};

        rst = 1; en = 0; size = `CACHE_D_WRITE_SW; addr = B; wdata = 0; mem_rdata = 0; sw = '0;
        m_reset();

        // reset values, read through the bus while rst is held
        #2;
        addr = B + 32'h00; #1; check("rst_sw", data_out, 32'h0);
        addr = B + 32'h04; #1; check("rst_led", data_out, 32'h0);
        addr = B + 32'h08; #1; check("rst_count", data_out, 32'h0);
        addr = B + 32'h0C; #1; check("rst_cmp", data_out, 32'hFFFFFFFF);
        addr = B + 32'h10; #1; check("rst_status", data_out, 32'h0);
        addr = B + 32'h14; #1; check("rst_ctrl", data_out, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        cyc();
        cyc();
        rst = 0;

        for (int i = 0; i < 14; i++) begin
            en = vecs[i].en; size = vecs[i].size; addr = vecs[i].addr;
            wdata = vecs[i].wdata; mem_rdata = vecs[i].mrd;
            #1;
            check({vecs[i].name, "_data_out"}, data_out, vecs[i].exp_do);
            check({vecs[i].name, "_we"}, {31'b0, mem_write_en}, {31'b0, vecs[i].exp_we});
            cyc();
        end
        en = 0;
        check("led_port", led, 32'hCAFE1234);

        // debounce: single-cycle glitch is rejected
        addr = B;
        sw = 24'h000001; cyc(); sw = '0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            check("sw_glitch", data_out, 32'h0);
        end
        // clean change appears exactly DEB+3 edges later
        sw = 24'h00000F;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            check($sformatf("sw_clean_e%0d", k), data_out, (k < DEB + 3) ? 32'h0 : 32'hF);
        end
        addr = B + 32'h10; #1; check("swchg_set", data_out, 32'h2);
        wr32(B + 32'h10, 32'h3);
        addr = B + 32'h10; #1; check("swchg_clr", data_out, 32'h0);

        // timer with auto-reload
        wr32(B + 32'h0C, 32'd5);
        wr32(B + 32'h14, 32'hD);
        wr32(B + 32'h08, 32'd0);
        addr = B + 32'h08;
        for (int k = 0; k < 14; k++) begin
            #1;
            check($sformatf("count_k%0d", k), data_out, k % 6);
            check($sformatf("irq_k%0d", k), {31'b0, irq}, (k >= 7) ? 32'h1 : 32'h0);
            cyc();
        end
        wr32(B + 32'h10, 32'h1);                 // count 2 -> 3, no match
        addr = B + 32'h10; #1;
        check("w1c_status", data_out, 32'h0);
        check("w1c_irq_lag", {31'b0, irq}, 32'h1);
        cyc();                                   // count 3 -> 4
        check("w1c_irq_clr", {31'b0, irq}, 32'h0);
        cyc();                                   // count 4 -> 5
        wr32(B + 32'h10, 32'h1);                 // match coincides with clear
        addr = B + 32'h10; #1;
        check("w1c_vs_set", data_out, 32'h1);
        cyc();
        check("w1c_vs_set_irq", {31'b0, irq}, 32'h1);

        // wrap without reload
        wr32(B + 32'h14, 32'h1);
        wr32(B + 32'h08, 32'hFFFFFFFE);
        addr = B + 32'h08; #1; check("wrap_0", data_out, 32'hFFFFFFFE);
        cyc(); check("wrap_1", data_out, 32'hFFFFFFFF);
        cyc(); check("wrap_2", data_out, 32'h00000000);
        wr32(B + 32'h14, 32'h0);
        wr32(B + 32'h10, 32'h3);

        // reset mid-count and mid-debounce
        wr32(B + 32'h08, 32'h20);
        sw = 24'h0000F0;
        for (int k = 0; k < 5; k++) cyc();
        rst = 1;
        addr = B + 32'h08; #1; check("rst2_count", data_out, 32'h0);
        addr = B + 32'h0C; #1; check("rst2_cmp", data_out, 32'hFFFFFFFF);
        addr = B + 32'h00; #1; check("rst2_sw", data_out, 32'h0);
        addr = B + 32'h04; #1; check("rst2_led_rd", data_out, 32'h0);
        check("rst2_irq", {31'b0, irq}, 32'h0);
        cyc();
        rst = 0;
        addr = B;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check($sformatf("sw_post_rst_e%0d", k), data_out, (k < DEB + 3) ? 32'h0 : 32'hF0);
        end

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            en = (r < 50);
            case ($urandom_range(0, 2))
                0:       size = `CACHE_D_WRITE_SB;
                1:       size = `CACHE_D_WRITE_SH;
                default: size = `CACHE_D_WRITE_SW;
            endcase
            r = $urandom_range(0, 99);
            if (r < 70)      addr = B + $urandom_range(0, 31);
            else if (r < 80) addr = B + $urandom_range(0, 255);
            else             addr = $urandom;
            wdata     = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom;
            mem_rdata = $urandom;
            if ($urandom_range(0, 9) == 0) sw = SWW'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
